// File: rtl/vram_arbiter.sv
// Single-port text VRAM arbiter: VGA reads (absolute priority), CPU reads and posted writes.
// Define VRAM_CLEAR_EN to build the lowest-priority screen-clear engine.
module vram_arbiter #(
    parameter int                 ADDR_W     = 12,
    parameter int                 DATA_W     = 8,
    parameter int                 WBUF_DEPTH = 4,
    parameter logic [DATA_W-1:0]  CLR_CHAR   = 8'h20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_ascii,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              wbuf_empty,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int PTR_W = $clog2(WBUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] RD_IDLE = 2'd0;
    localparam logic [1:0] RD_PEND = 2'd1;
    localparam logic [1:0] RD_DATA = 2'd2;

    logic [1:0]        rd_state_q, rd_state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

    logic [ADDR_W-1:0] wbuf_addr_q [WBUF_DEPTH];
    logic [ADDR_W-1:0] wbuf_addr_d [WBUF_DEPTH];
    logic [DATA_W-1:0] wbuf_data_q [WBUF_DEPTH];
    logic [DATA_W-1:0] wbuf_data_d [WBUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  wcount_q, wcount_d;

    logic wbuf_full;
    logic wr_gnt;
    logic rd_gnt;
    logic push;
    logic pop;
    logic rd_issue;

`ifdef VRAM_CLEAR_EN
    localparam logic [4:0] CLR_LAST_ROW = 5'd31;
    localparam logic [6:0] CLR_LAST_COL = 7'd85;

    logic              clr_busy_q, clr_busy_d;
    logic [4:0]        clr_row_q, clr_row_d;
    logic [6:0]        clr_col_q, clr_col_d;
    logic              clr_step;
    logic [ADDR_W-1:0] clr_addr;

    assign clr_addr = ADDR_W'({clr_row_q, clr_col_q});
    assign clr_busy = clr_busy_q;
`else
    logic unused_clr_start;
    assign unused_clr_start = clr_start;
    assign clr_busy         = 1'b0;
`endif

    assign wbuf_empty = (wcount_q == '0);
    assign wbuf_full  = (wcount_q == CNT_W'(WBUF_DEPTH));

    // Reads wait for the FIFO to drain, which is what keeps read-after-write ordering.
    assign wr_gnt  = cpu_req & cpu_we & ~wbuf_full & ~clr_busy;
    assign rd_gnt  = cpu_req & ~cpu_we & wbuf_empty & (rd_state_q == RD_IDLE) & ~clr_busy;
    assign cpu_gnt = wr_gnt | rd_gnt;
    assign push    = wr_gnt;

    assign vga_ascii  = ram_rdata;
    assign cpu_rvalid = (rd_state_q == RD_DATA);
    assign cpu_rdata  = cpu_rvalid ? ram_rdata : cpu_rdata_q;

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = CLR_CHAR;
        rd_issue  = 1'b0;
        pop       = 1'b0;
`ifdef VRAM_CLEAR_EN
        clr_step  = 1'b0;
`endif
        if (vga_req) begin
            ram_en   = 1'b1;
            ram_addr = vga_addr;
        end else if (rd_state_q == RD_PEND) begin
            ram_en   = 1'b1;
            ram_addr = rd_addr_q;
            rd_issue = 1'b1;
        end else if (!wbuf_empty) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = wbuf_addr_q[rd_ptr_q];
            ram_wdata = wbuf_data_q[rd_ptr_q];
            pop       = 1'b1;
        end
`ifdef VRAM_CLEAR_EN
        else if (clr_busy_q) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = clr_addr;
            ram_wdata = CLR_CHAR;
            clr_step  = 1'b1;
        end
`endif
    end

    always_comb begin
        rd_state_d  = rd_state_q;
        rd_addr_d   = rd_addr_q;
        cpu_rdata_d = cpu_rdata_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (rd_gnt) begin
                    rd_state_d = RD_PEND;
                    rd_addr_d  = cpu_addr;
                end
            end
            RD_PEND: begin
                if (rd_issue) begin
                    rd_state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                cpu_rdata_d = ram_rdata;
                rd_state_d  = RD_IDLE;
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        wcount_d = wcount_q;
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            wbuf_addr_d[i] = wbuf_addr_q[i];
            wbuf_data_d[i] = wbuf_data_q[i];
        end
        if (push) begin
            wbuf_addr_d[wr_ptr_q] = cpu_addr;
            wbuf_data_d[wr_ptr_q] = cpu_wdata;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            wcount_d = wcount_q + CNT_W'(1);
        end else if (!push && pop) begin
            wcount_d = wcount_q - CNT_W'(1);
        end
    end

`ifdef VRAM_CLEAR_EN
    // Column runs fastest; the last write at {31,85} drops busy on the following cycle.
    always_comb begin
        clr_busy_d = clr_busy_q;
        clr_row_d  = clr_row_q;
        clr_col_d  = clr_col_q;
        if (!clr_busy_q) begin
            if (clr_start) begin
                clr_busy_d = 1'b1;
                clr_row_d  = '0;
                clr_col_d  = '0;
            end
        end else if (clr_step) begin
            if (clr_col_q == CLR_LAST_COL) begin
                clr_col_d = '0;
                if (clr_row_q == CLR_LAST_ROW) begin
                    clr_busy_d = 1'b0;
                end else begin
                    clr_row_d = clr_row_q + 5'd1;
                end
            end else begin
                clr_col_d = clr_col_q + 7'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_busy_q <= 1'b0;
            clr_row_q  <= '0;
            clr_col_q  <= '0;
        end else begin
            clr_busy_q <= clr_busy_d;
            clr_row_q  <= clr_row_d;
            clr_col_q  <= clr_col_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q  <= RD_IDLE;
            cpu_rdata_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            wcount_q    <= '0;
        end else begin
            rd_state_q  <= rd_state_d;
            cpu_rdata_q <= cpu_rdata_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            wcount_q    <= wcount_d;
        end
        rd_addr_q <= rd_addr_d;
    end

    // FIFO storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            wbuf_addr_q[i] <= wbuf_addr_d[i];
            wbuf_data_q[i] <= wbuf_data_d[i];
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a VRAM model, golden shadow memory and scoreboards.
// Build with VRAM_CLEAR_EN defined to exercise the clear engine.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        vga_req;
    logic [11:0] vga_addr;
    logic [7:0]  vga_ascii;
    logic        cpu_req;
    logic        cpu_we;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    logic [7:0]  cpu_rdata;
    logic        wbuf_empty;
    logic        clr_start;
    logic        clr_busy;
    logic        ram_en;
    logic        ram_we;
    logic [11:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    always #5 clk = ~clk;

    vram_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .vga_req    (vga_req),
        .vga_addr   (vga_addr),
        .vga_ascii  (vga_ascii),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .wbuf_empty (wbuf_empty),
        .clr_start  (clr_start),
        .clr_busy   (clr_busy),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    function automatic logic [7:0] init_val(input logic [11:0] a);
        return (a == 12'h085) ? 8'h41 : (a[7:0] ^ 8'h5A);
    endfunction

    // VRAM model: registered read, one access per cycle.
    logic [7:0] mem [4096];
    logic       ram_init;

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 4096; i++) mem[i] <= init_val(12'(i));
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    int          n_cmp;
    int          n_bad;
    int          cyc;
    int          rd_gnt_cyc;
    int          last_lat;
    int          rvalid_cnt;
    int          clr_writes;
    int          clr_bad;
    bit          vga_chk;
    bit          clr_mode;
    logic [7:0]  gold [4096];
    logic [7:0]  vga_q [$];
    logic [7:0]  rd_q [$];
    logic [19:0] wr_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_access(input bit we, input logic [11:0] a, input logic [7:0] d);
        bit granted;
        granted   = 1'b0;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (cpu_gnt) begin
                granted = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!granted) check("cpu_gnt_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
    endtask

    task automatic wait_rvalid(input int start_cnt);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (rvalid_cnt != start_cnt) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) check("rvalid_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50; i++) begin
            if (wbuf_empty) break;
            tick();
        end
    endtask

    initial begin
        int n0;
        bit done;
        n_cmp = 0; n_bad = 0; cyc = 0; rd_gnt_cyc = 0; last_lat = -1; rvalid_cnt = 0;
        clr_writes = 0; clr_bad = 0; vga_chk = 1'b0; clr_mode = 1'b0;
        rst = 1'b1; ram_init = 1'b1;
        vga_req = 1'b0; vga_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        clr_start = 1'b0;

        // Scoreboard monitor, sampling on the falling edge.
        fork
            forever begin
                @(negedge clk);
                cyc++;
                if (ram_init) begin
                    for (int i = 0; i < 4096; i++) gold[i] = init_val(12'(i));
                end
                if (vga_chk) check("vga_ascii", 32'(vga_ascii), 32'(vga_q.pop_front()));
                vga_chk = vga_req;
                if (vga_req) vga_q.push_back(gold[vga_addr]);
                if (cpu_req && cpu_gnt) begin
                    if (cpu_we) begin
                        wr_q.push_back({cpu_addr, cpu_wdata});
                        gold[cpu_addr] = cpu_wdata;
                    end else begin
                        rd_q.push_back(gold[cpu_addr]);
                        rd_gnt_cyc = cyc;
                    end
                end
                if (cpu_rvalid) begin
                    rvalid_cnt++;
                    last_lat = cyc - rd_gnt_cyc;
                    if (rd_q.size() == 0) check("rvalid_unexpected", 32'd1, 32'd0);
                    else check("cpu_rdata", 32'(cpu_rdata), 32'(rd_q.pop_front()));
                end
                if (ram_en && ram_we) begin
                    if (wr_q.size() > 0) begin
                        check("ram_write", 32'({ram_addr, ram_wdata}), 32'(wr_q.pop_front()));
                    end else if (clr_mode) begin
                        clr_writes++;
                        if (ram_wdata !== 8'h20 || ram_addr[6:0] > 7'd85) clr_bad++;
                        gold[ram_addr] = ram_wdata;
                    end else begin
                        check("ram_write_unexpected", 32'({ram_addr, ram_wdata}), 32'hFFFFFFFF);
                    end
                end
                if (rst) begin
                    rd_q.delete();
                    wr_q.delete();
                end
            end
        join_none

        // Reset state
        repeat (3) tick();
        ram_init = 1'b0;
        check("rst_rvalid", 32'(cpu_rvalid), 32'd0);
        check("rst_rdata", 32'(cpu_rdata), 32'd0);
        check("rst_wbuf_empty", 32'(wbuf_empty), 32'd1);
        check("rst_clr_busy", 32'(clr_busy), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // VGA read of a preloaded cell
        vga_req = 1'b1; vga_addr = 12'h085;
        #1;
        check("vga_mux_en", 32'({ram_en, ram_we}), 32'b10);
        check("vga_mux_addr", 32'(ram_addr), 32'h085);
        tick();
        vga_req = 1'b0;
        check("vga_read_41", 32'(vga_ascii), 32'h41);
        check("idle_gnt", 32'(cpu_gnt), 32'd0);

        // Posted write then read-back
        cpu_access(1'b1, 12'h001, 8'h48);
        check("wbuf_not_empty", 32'(wbuf_empty), 32'd0);
        tick();
        check("wbuf_empty_2cyc", 32'(wbuf_empty), 32'd1);
        n0 = rvalid_cnt;
        cpu_access(1'b0, 12'h001, 8'h00);
        wait_rvalid(n0);
        check("rd_latency_min", 32'(last_lat), 32'd2);
        check("rdata_held", 32'(cpu_rdata), 32'h48);

        // Five writes against continuous VGA traffic
        vga_req = 1'b1; vga_addr = 12'h100;
        cpu_req = 1'b1; cpu_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cpu_addr = 12'h010 + 12'(i); cpu_wdata = 8'hA0 + 8'(i);
            #1;
            check("fill_gnt", 32'(cpu_gnt), 32'd1);
            @(posedge clk); #1;
            vga_addr = vga_addr + 12'd1;
        end
        cpu_addr = 12'h014; cpu_wdata = 8'hA4;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("full_gnt", 32'(cpu_gnt), 32'd0);
            @(posedge clk); #1;
            vga_addr = vga_addr + 12'd1;
        end
        vga_req = 1'b0;
        #1;
        check("full_gnt_vga_drop", 32'(cpu_gnt), 32'd0);
        check("head_write_addr", 32'({ram_we, ram_addr}), 32'h1010);
        @(posedge clk); #1;
        #1;
        check("fifth_gnt", 32'(cpu_gnt), 32'd1);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        wait_drain();
        check("wr_order_drained", 32'(wr_q.size()), 32'd0);

        // Pending read held off by three VGA cycles
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h012;
        #1;
        check("rd_gnt", 32'(cpu_gnt), 32'd1);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        vga_req = 1'b1; vga_addr = 12'h140;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("rd_stall_vga_addr", 32'({ram_we, ram_addr}), 32'({1'b0, vga_addr}));
            check("rd_stall_rvalid", 32'(cpu_rvalid), 32'd0);
            @(posedge clk); #1;
            vga_addr = vga_addr + 12'd1;
        end
        vga_req = 1'b0;
        #1;
        check("rd_issue_4th", 32'({ram_en, ram_we, ram_addr}), 32'h2012);
        @(posedge clk); #1;
        check("rd_rvalid_5th", 32'(cpu_rvalid), 32'd1);
        check("rd_rdata_a2", 32'(cpu_rdata), 32'hA2);
        tick();
        check("rd_latency_vga", 32'(last_lat), 32'd5);

        // Reset in RD_PEND with two queued writes
        vga_req = 1'b1; vga_addr = 12'h180;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h001;
        #1;
        check("rst_case_rd_gnt", 32'(cpu_gnt), 32'd1);
        @(posedge clk); #1;
        n0 = rvalid_cnt;
        cpu_we = 1'b1; cpu_addr = 12'h200; cpu_wdata = 8'h11;
        #1;
        check("rst_case_wr0_gnt", 32'(cpu_gnt), 32'd1);
        @(posedge clk); #1;
        cpu_addr = 12'h201; cpu_wdata = 8'h22;
        #1;
        check("rst_case_wr1_gnt", 32'(cpu_gnt), 32'd1);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        check("rst_case_queued", 32'(wbuf_empty), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0; vga_req = 1'b0;
        check("rst_abort_empty", 32'(wbuf_empty), 32'd1);
        check("rst_abort_rvalid", 32'(cpu_rvalid), 32'd0);
        repeat (10) tick();
        check("rst_no_rvalid", 32'(rvalid_cnt), 32'(n0));
        check("rst_no_write_200", 32'(mem[12'h200]), 32'(init_val(12'h200)));
        check("rst_no_write_201", 32'(mem[12'h201]), 32'(init_val(12'h201)));

`ifdef VRAM_CLEAR_EN
        // Screen clear with interleaved VGA reads of never-cleared columns
        clr_mode = 1'b1;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        check("clr_busy_set", 32'(clr_busy), 32'd1);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h300; cpu_wdata = 8'h77;
        #1;
        check("clr_cpu_gnt_blocked", 32'(cpu_gnt), 32'd0);
        cpu_req = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            vga_req   = (i % 3 == 0);
            vga_addr  = {5'd7, 7'(100 + (i % 28))};
            clr_start = (i == 100);
            tick();
            if (!clr_busy) begin
                done = 1'b1;
                break;
            end
        end
        vga_req = 1'b0; clr_start = 1'b0;
        check("clr_done", 32'(done), 32'd1);
        repeat (3) tick();
        check("clr_busy_low", 32'(clr_busy), 32'd0);
        check("clr_write_count", 32'(clr_writes), 32'd2752);
        check("clr_bad_writes", 32'(clr_bad), 32'd0);
        clr_mode = 1'b0;
`else
        // Without the clear engine clr_start has no effect
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        check("noclr_busy", 32'(clr_busy), 32'd0);
        repeat (3) tick();
        check("noclr_busy_later", 32'(clr_busy), 32'd0);
        done = 1'b1;
`endif
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
